// File: rtl/music_pkg.sv
// Shared definitions for the song ROMs and the music player.
// - NOTE_W   : width of a ROM word (half-period in clk cycles)
// - REST_VAL : ROM word that marks a rest (silence)
// - M*/H*/HH*/D* : half-period counts for the note names at a 100 MHz clock
//                  (M = middle octave, H = high, HH = two up, D = low; S = sharp)
// - state_t  : player FSM encoding
package music_pkg;

    localparam int NOTE_W   = 33;
    localparam int REST_VAL = 2500;

    // Low octave (G3..B3)
    localparam logic [NOTE_W-1:0] D5  = 33'd255102;
    localparam logic [NOTE_W-1:0] D5S = 33'd240790;
    localparam logic [NOTE_W-1:0] D6  = 33'd227273;
    localparam logic [NOTE_W-1:0] D6S = 33'd214519;
    localparam logic [NOTE_W-1:0] D7  = 33'd202478;

    // Middle octave (C4..B4)
    localparam logic [NOTE_W-1:0] M1  = 33'd191113;
    localparam logic [NOTE_W-1:0] M1S = 33'd180388;
    localparam logic [NOTE_W-1:0] M2  = 33'd170265;
    localparam logic [NOTE_W-1:0] M2S = 33'd160705;
    localparam logic [NOTE_W-1:0] M3  = 33'd151685;
    localparam logic [NOTE_W-1:0] M4  = 33'd143172;
    localparam logic [NOTE_W-1:0] M4S = 33'd135139;
    localparam logic [NOTE_W-1:0] M5  = 33'd127551;
    localparam logic [NOTE_W-1:0] M5S = 33'd120395;
    localparam logic [NOTE_W-1:0] M6  = 33'd113636;
    localparam logic [NOTE_W-1:0] M6S = 33'd107259;
    localparam logic [NOTE_W-1:0] M7  = 33'd101239;

    // High octave (C5..B5)
    localparam logic [NOTE_W-1:0] H1  = 33'd95556;
    localparam logic [NOTE_W-1:0] H1S = 33'd90194;
    localparam logic [NOTE_W-1:0] H2  = 33'd85131;
    localparam logic [NOTE_W-1:0] H2S = 33'd80353;
    localparam logic [NOTE_W-1:0] H3  = 33'd75843;
    localparam logic [NOTE_W-1:0] H4  = 33'd71586;
    localparam logic [NOTE_W-1:0] H4S = 33'd67569;
    localparam logic [NOTE_W-1:0] H5  = 33'd63776;
    localparam logic [NOTE_W-1:0] H5S = 33'd60197;
    localparam logic [NOTE_W-1:0] H6  = 33'd56818;
    localparam logic [NOTE_W-1:0] H6S = 33'd53629;
    localparam logic [NOTE_W-1:0] H7  = 33'd50619;

    // Two octaves up (C6, D6)
    localparam logic [NOTE_W-1:0] HH1 = 33'd47778;
    localparam logic [NOTE_W-1:0] HH2 = 33'd42566;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

endpackage

// File: rtl/music_player_if.sv
// Bundle between the game control / note ROM side (master) and the player (slave).
//  start, stop, loop_en : control from game logic
//  rom_addr             : player -> ROM address
//  rom_note             : ROM -> player data (registered ROM, 1-cycle latency)
//  buzz, busy, done     : player status and buzzer drive
interface music_player_if #(
    parameter int ADDR_W = 8,
    parameter int NOTE_W = 33
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_note;
    logic              buzz;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, loop_en, rom_note,
        input  rom_addr, buzz, busy, done
    );

    modport slave (
        input  start, stop, loop_en, rom_note,
        output rom_addr, buzz, busy, done
    );
endinterface

// File: rtl/tone_gen.sv
// Square-wave generator driven by a half-period count.
//  clk, rst    : clock, synchronous active-high reset
//  half_period : candidate note, captured when load is high
//  load        : 1-cycle strobe to take half_period
//  buzz        : square wave, toggles every note_reg cycles
// A note of 0 or REST_VAL is silence. Reloading the same note leaves the
// running phase untouched so repeated notes sound as one continuous tone.
module tone_gen #(
    parameter int NOTE_W   = music_pkg::NOTE_W,
    parameter int REST_VAL = music_pkg::REST_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NOTE_W-1:0] half_period,
    input  logic              load,
    output logic              buzz
);

    localparam logic [NOTE_W-1:0] REST = NOTE_W'(REST_VAL);

    logic [NOTE_W-1:0] note_reg;
    logic [NOTE_W-1:0] tone_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            note_reg <= '0;
            tone_cnt <= '0;
            buzz     <= 1'b0;
        end else if (load && (half_period != note_reg)) begin
            // New pitch: restart the phase from a low level
            note_reg <= half_period;
            tone_cnt <= '0;
            buzz     <= 1'b0;
        end else if ((note_reg == '0) || (note_reg == REST)) begin
            tone_cnt <= '0;
            buzz     <= 1'b0;
        end else if (tone_cnt == note_reg - 1'b1) begin
            tone_cnt <= '0;
            buzz     <= ~buzz;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/music_player.sv
// Song sequencer: walks the note ROM one address per beat and feeds each
// note to tone_gen.
//  clk, rst : clock, synchronous active-high reset
//  bus      : music_player_if slave (start/stop/loop_en in, rom_addr out,
//             rom_note in, buzz/busy/done out)
// Each address occupies BEAT_TICKS cycles: one FETCH cycle (beat 0) followed by
// PLAY. Because the ROM is registered, its data for a new address is only valid
// one cycle after FETCH, so the load into tone_gen is issued from a one-cycle
// delayed strobe (load_p). Stop and song end load a zero note, which silences
// tone_gen and guarantees the next song starts from a clean phase.
module music_player #(
    parameter int BEAT_TICKS = 12_500_000,
    parameter int SONG_LEN   = 144,
    parameter int ADDR_W     = 8,
    parameter int NOTE_W     = music_pkg::NOTE_W,
    parameter int REST_VAL   = music_pkg::REST_VAL
) (
    input  logic           clk,
    input  logic           rst,
    music_player_if.slave  bus
);
    import music_pkg::*;

    localparam int BW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam logic [BW-1:0]     BEAT_LAST = BW'(BEAT_TICKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [BW-1:0]     beat_cnt;
    logic [BW-1:0]     beat_nxt;
    logic              done_nxt;
    logic              load_p;
    logic              load_nxt;
    logic              silence;

    logic              tone_load;
    logic [NOTE_W-1:0] tone_note;

    assign bus.busy  = (state != ST_IDLE);
    assign tone_load = load_p | silence;
    assign tone_note = silence ? '0 : bus.rom_note;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bus.rom_addr <= '0;
            beat_cnt     <= '0;
            bus.done     <= 1'b0;
            load_p       <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.rom_addr <= addr_nxt;
            beat_cnt     <= beat_nxt;
            bus.done     <= done_nxt;
            load_p       <= load_nxt;
        end
    end

    // Priority: stop > start > beat stepping
    always_comb begin
        state_nxt = state;
        addr_nxt  = bus.rom_addr;
        beat_nxt  = beat_cnt;
        done_nxt  = 1'b0;
        load_nxt  = 1'b0;
        silence   = 1'b0;

        if (bus.stop) begin
            state_nxt = ST_IDLE;
            beat_nxt  = '0;
            silence   = 1'b1;
        end else if (bus.start) begin
            state_nxt = ST_FETCH;
            addr_nxt  = '0;
            beat_nxt  = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                end
                ST_FETCH: begin
                    state_nxt = ST_PLAY;
                    beat_nxt  = beat_cnt + 1'b1;
                    load_nxt  = 1'b1;
                end
                ST_PLAY: begin
                    if (beat_cnt == BEAT_LAST) begin
                        beat_nxt = '0;
                        if (bus.rom_addr < ADDR_LAST) begin
                            addr_nxt  = bus.rom_addr + 1'b1;
                            state_nxt = ST_FETCH;
                        end else if (bus.loop_en) begin
                            addr_nxt  = '0;
                            state_nxt = ST_FETCH;
                        end else begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                            silence   = 1'b1;
                        end
                    end else begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    tone_gen #(
        .NOTE_W   (NOTE_W),
        .REST_VAL (REST_VAL)
    ) u_tone_gen (
        .clk         (clk),
        .rst         (rst),
        .half_period (tone_note),
        .load        (tone_load),
        .buzz        (bus.buzz)
    );

endmodule

// File: tb/tb_music_player.sv
// Bench for music_player with BEAT_TICKS=16, SONG_LEN=4 and a registered
// behavioural ROM holding {3, 3, REST, 5}. Inputs are driven and outputs
// sampled on the falling clock edge. k counts falling edges after the edge
// that accepted start (k=0 is the first sample after that edge).
module tb_music_player;
    import music_pkg::*;

    localparam int BT = 16;
    localparam int SL = 4;
    localparam int AW = 8;
    localparam int NW = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    music_player_if #(.ADDR_W(AW), .NOTE_W(NW)) bus ();

    logic [NW-1:0] mem [4];
    always @(posedge clk) bus.rom_note <= mem[bus.rom_addr[1:0]];

    music_player #(
        .BEAT_TICKS (BT),
        .SONG_LEN   (SL),
        .ADDR_W     (AW),
        .NOTE_W     (NW),
        .REST_VAL   (REST_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        bit            chk_addr;
        logic          busy;
        logic          done;
        logic          buzz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Expected outputs k samples after start, for a song started from silence.
    // Notes load 2 cycles after each address change; addrs 0-1 (note 3) share
    // one phase, addr 2 rests, addr 3 is note 5. When looping, the first two
    // samples of a new pass still hear note 5 of the previous pass.
    function automatic exp_t model(int k, bit looping, bit zero1);
        exp_t e;
        int   kk;
        kk         = looping ? (k % 64) : k;
        e.addr     = AW'(kk / 16);
        e.chk_addr = 1'b1;
        e.busy     = 1'b1;
        e.done     = 1'b0;
        e.buzz     = 1'b0;
        if (!looping && k >= 64) begin
            e.busy     = 1'b0;
            e.done     = (k == 64);
            e.chk_addr = 1'b0;
        end else if (kk < 2) begin
            e.buzz = (looping && k >= 64) ? (((kk + 14) / 5) % 2 == 1) : 1'b0;
        end else if (kk < 34) begin
            e.buzz = (zero1 && kk >= 18) ? 1'b0 : (((kk - 2) / 3) % 2 == 1);
        end else if (kk < 50) begin
            e.buzz = 1'b0;
        end else begin
            e.buzz = (((kk - 50) / 5) % 2 == 1);
        end
        return e;
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.busy, bus.done, bus.buzz, bus.rom_addr} !== {3'b000, AW'(0)}) begin
                n_bad++;
                $display("FAIL reset cyc=%0d busy/done/buzz/addr got %b%b%b/%0d want 000/0",
                         i, bus.busy, bus.done, bus.buzz, bus.rom_addr);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.buzz} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_reset busy/done/buzz got %b%b%b want 000",
                     bus.busy, bus.done, bus.buzz);
        end
    endtask

    task automatic test_play_once();
        exp_t e;
        bus.loop_en = 1'b0;
        for (int k = 0; k < 72; k++) sb.push_back(model(k, 1'b0, 1'b0));
        pulse_start();
        for (int k = 0; k < 72; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.busy, bus.done, bus.buzz} !== {e.busy, e.done, e.buzz}) begin
                n_bad++;
                $display("FAIL play_once k=%0d busy/done/buzz got %b%b%b want %b%b%b",
                         k, bus.busy, bus.done, bus.buzz, e.busy, e.done, e.buzz);
            end
            if (e.chk_addr) begin
                n_cmp++;
                if (bus.rom_addr !== e.addr) begin
                    n_bad++;
                    $display("FAIL play_once_addr k=%0d got %0d want %0d", k, bus.rom_addr, e.addr);
                end
            end
        end
    endtask

    task automatic test_loop();
        exp_t e;
        bus.loop_en = 1'b1;
        for (int k = 0; k < 140; k++) sb.push_back(model(k, 1'b1, 1'b0));
        pulse_start();
        for (int k = 0; k < 140; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.busy, bus.done, bus.buzz} !== {e.busy, e.done, e.buzz}) begin
                n_bad++;
                $display("FAIL loop k=%0d busy/done/buzz got %b%b%b want %b%b%b",
                         k, bus.busy, bus.done, bus.buzz, e.busy, e.done, e.buzz);
            end
            n_cmp++;
            if (bus.rom_addr !== e.addr) begin
                n_bad++;
                $display("FAIL loop_addr k=%0d got %0d want %0d", k, bus.rom_addr, e.addr);
            end
        end
        bus.loop_en = 1'b0;
        bus.stop    = 1'b1;
        @(negedge clk);
        bus.stop    = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.done, bus.buzz} !== 3'b000) begin
            n_bad++;
            $display("FAIL loop_stop busy/done/buzz got %b%b%b want 000", bus.busy, bus.done, bus.buzz);
        end
    endtask

    task automatic test_stop();
        exp_t e;
        int   seen_done;
        for (int k = 0; k < 24; k++) sb.push_back(model(k, 1'b0, 1'b0));
        pulse_start();
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.busy, bus.buzz, bus.rom_addr} !== {e.busy, e.buzz, e.addr}) begin
                n_bad++;
                $display("FAIL stop_pre k=%0d busy/buzz/addr got %b%b/%0d want %b%b/%0d",
                         k, bus.busy, bus.buzz, bus.rom_addr, e.busy, e.buzz, e.addr);
            end
        end
        // k=23 is beat 7 of address 1, with buzz high
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.done, bus.buzz} !== 3'b000) begin
            n_bad++;
            $display("FAIL stop busy/done/buzz got %b%b%b want 000", bus.busy, bus.done, bus.buzz);
        end
        seen_done = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.buzz) seen_done++;
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_bad++;
            $display("FAIL stop_stays_idle active cycles got %0d want 0", seen_done);
        end
    endtask

    task automatic test_restart();
        exp_t e;
        for (int k = 0; k < 24; k++) sb.push_back(model(k, 1'b0, 1'b0));
        pulse_start();
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.busy, bus.buzz, bus.rom_addr} !== {e.busy, e.buzz, e.addr}) begin
                n_bad++;
                $display("FAIL restart_pre k=%0d busy/buzz/addr got %b%b/%0d want %b%b/%0d",
                         k, bus.busy, bus.buzz, bus.rom_addr, e.busy, e.buzz, e.addr);
            end
        end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.done, bus.buzz} !== 3'b000) begin
            n_bad++;
            $display("FAIL start_stop_same busy/done/buzz got %b%b%b want 000",
                     bus.busy, bus.done, bus.buzz);
        end
        // Play into the rest at address 2, then restart mid-song
        for (int k = 0; k < 41; k++) sb.push_back(model(k, 1'b0, 1'b0));
        pulse_start();
        for (int k = 0; k < 41; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.busy, bus.buzz, bus.rom_addr} !== {e.busy, e.buzz, e.addr}) begin
                n_bad++;
                $display("FAIL restart_mid k=%0d busy/buzz/addr got %b%b/%0d want %b%b/%0d",
                         k, bus.busy, bus.buzz, bus.rom_addr, e.busy, e.buzz, e.addr);
            end
        end
        for (int k = 0; k < 34; k++) sb.push_back(model(k, 1'b0, 1'b0));
        pulse_start();
        for (int k = 0; k < 34; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.busy, bus.done, bus.buzz, bus.rom_addr} !== {e.busy, e.done, e.buzz, e.addr}) begin
                n_bad++;
                $display("FAIL restart_post k=%0d busy/done/buzz/addr got %b%b%b/%0d want %b%b%b/%0d",
                         k, bus.busy, bus.done, bus.buzz, bus.rom_addr, e.busy, e.done, e.buzz, e.addr);
            end
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic test_reset_mid_and_zero();
        exp_t e;
        for (int k = 0; k < 24; k++) sb.push_back(model(k, 1'b0, 1'b0));
        pulse_start();
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.busy, bus.buzz} !== {e.busy, e.buzz}) begin
                n_bad++;
                $display("FAIL rst_pre k=%0d busy/buzz got %b%b want %b%b",
                         k, bus.busy, bus.buzz, e.busy, e.buzz);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.done, bus.buzz, bus.rom_addr} !== {3'b000, AW'(0)}) begin
            n_bad++;
            $display("FAIL rst_mid busy/done/buzz/addr got %b%b%b/%0d want 000/0",
                     bus.busy, bus.done, bus.buzz, bus.rom_addr);
        end
        @(negedge clk);
        // Address 1 holds 0: silent for that beat
        mem[1] = '0;
        for (int k = 0; k < 68; k++) sb.push_back(model(k, 1'b0, 1'b1));
        pulse_start();
        for (int k = 0; k < 68; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({bus.busy, bus.done, bus.buzz} !== {e.busy, e.done, e.buzz}) begin
                n_bad++;
                $display("FAIL zero_note k=%0d busy/done/buzz got %b%b%b want %b%b%b",
                         k, bus.busy, bus.done, bus.buzz, e.busy, e.done, e.buzz);
            end
        end
        mem[1] = NW'(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        mem[0] = NW'(3);
        mem[1] = NW'(3);
        mem[2] = NW'(REST_VAL);
        mem[3] = NW'(5);
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        rst         = 1'b1;

        test_reset();
        test_play_once();
        test_loop();
        test_stop();
        test_restart();
        test_reset_mid_and_zero();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
